// File: rtl/sipu_out_streamer.sv
// Streams the processed image out of the SIPU output memory onto a valid/ready pixel stream.
// Optional running checksum on stream_cksum is built when SIPU_STREAM_CKSUM_EN is defined.
module sipu_out_streamer #(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 32,
  parameter int unsigned NUM_PIX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              en_out_mem,
  output logic              out_mem_read,
  output logic [ADDR_W-1:0] out_mem_addr,
  input  logic [DATA_W-1:0] out_mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_last,
  output logic              busy,
  output logic              stream_done,
  output logic [15:0]       stream_cksum,
  output logic [1:0]        dbg_state
);

  // Stream handshake: a pixel transfers on a rising edge where pix_valid and
  // pix_ready are both high; once raised, pix_valid and pix_data hold until then.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              accept_start;
  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        occ_after_pop;

  always_comb begin
    accept_start  = (state_q == S_IDLE) && start;
    push          = inflight_q;
    pop           = (count_q != 2'd0) && pix_ready;
    // Credit counts the slot freed by this cycle's pop so a full-rate stream never bubbles.
    occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue         = (state_q == S_RUN) && (occ_after_pop < 3'd2);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && (rd_addr_q == LAST_IDX)) state_d = S_DRAIN;
      S_DRAIN: if (pop && pix_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_addr_d = rd_addr_q;
    if (accept_start) begin
      rd_addr_d = '0;
    end else if (issue && (rd_addr_q != LAST_IDX)) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end

    out_idx_d = out_idx_q;
    if (accept_start) begin
      out_idx_d = '0;
    end else if (pop) begin
      out_idx_d = out_idx_q + 1'b1;
    end

    inflight_d = issue;

    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      buf_d[wr_ptr_q] = out_mem_rdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      out_idx_q  <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      out_idx_q  <= out_idx_d;
      inflight_q <= inflight_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign en_out_mem   = issue;
  assign out_mem_read = issue;
  assign out_mem_addr = rd_addr_q;
  assign pix_valid    = (count_q != 2'd0);
  assign pix_data     = buf_q[rd_ptr_q];
  assign pix_last     = pix_valid && (out_idx_q == LAST_IDX);
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign stream_done  = (state_q == S_DONE);
  assign dbg_state    = state_q;

`ifdef SIPU_STREAM_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (accept_start) begin
      cksum_d = 16'd0;
    end else if (pop) begin
      cksum_d = cksum_q + 16'(pix_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cksum_q <= 16'd0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign stream_cksum = cksum_q;
`else
  assign stream_cksum = 16'd0;
`endif

endmodule

// File: tb/tb_sipu_out_streamer.sv
// Self-checking bench for sipu_out_streamer: a 64-pixel instance and a 1-pixel instance.
module tb_sipu_out_streamer;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 32;
  localparam int NUM_PIX = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main instance (64 pixels) ----------------
  logic              start = 1'b0;
  logic              en_out_mem, out_mem_read;
  logic [ADDR_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] out_mem_rdata = '0;
  logic              pix_valid;
  logic              pix_ready = 1'b1;
  logic [DATA_W-1:0] pix_data;
  logic              pix_last, busy, stream_done;
  logic [15:0]       stream_cksum;
  logic [1:0]        dbg_state;

  sipu_out_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PIX(NUM_PIX)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .en_out_mem(en_out_mem), .out_mem_read(out_mem_read), .out_mem_addr(out_mem_addr),
    .out_mem_rdata(out_mem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .busy(busy), .stream_done(stream_done), .stream_cksum(stream_cksum), .dbg_state(dbg_state)
  );

  // Output memory preloaded with addr[7:0], one-cycle read latency.
  always @(posedge clk) if (en_out_mem && out_mem_read) out_mem_rdata <= out_mem_addr[7:0];

  // ---------------- single-pixel instance ----------------
  logic              start1 = 1'b0;
  logic              en1, rd1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] rdata1 = '0;
  logic              valid1;
  logic              ready1 = 1'b1;
  logic [DATA_W-1:0] data1;
  logic              last1, busy1, done1;
  logic [15:0]       cksum1;
  logic [1:0]        dbg1;

  sipu_out_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PIX(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .en_out_mem(en1), .out_mem_read(rd1), .out_mem_addr(addr1), .out_mem_rdata(rdata1),
    .pix_valid(valid1), .pix_ready(ready1), .pix_data(data1), .pix_last(last1),
    .busy(busy1), .stream_done(done1), .stream_cksum(cksum1), .dbg_state(dbg1)
  );

  always @(posedge clk) if (en1 && rd1) rdata1 <= (addr1 == 0) ? 8'hA5 : 8'h00;

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0] exp_q[$];   // {last, data}
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued_cnt, hs_cnt, done_cnt, max_out;
  int first_hs_cyc, last_hs_cyc;
  logic              stalled = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;
  logic [15:0]       exp_ck;

  initial begin
`ifdef SIPU_STREAM_CKSUM_EN
    exp_ck = 16'h07E0;
`else
    exp_ck = 16'h0000;
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_counters();
    issued_cnt   = 0;
    hs_cnt       = 0;
    done_cnt     = 0;
    max_out      = 0;
    first_hs_cyc = -10;
    last_hs_cyc  = -10;
  endtask

  task automatic pulse_start(input bit push_exp);
    if (push_exp)
      for (int i = 0; i < NUM_PIX; i++) exp_q.push_back({(i == NUM_PIX - 1), DATA_W'(i)});
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic run_until_done(input int mode, input bit restart10);
    int n = 0;
    bit restarted = 1'b0;
    while (!(done_cnt > 0 && exp_q.size() == 0) && n < 2000) begin
      pix_ready = (mode == 0) ? 1'b1 : (n % 3 == 0);
      if (restart10 && !restarted && hs_cnt >= 10) begin
        start = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    pix_ready = 1'b1;
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL stream_timeout beats=%0d done=%0d expected stream completion", hs_cnt, done_cnt);
    end
  endtask

  // Monitor samples on the falling edge: values here are what the next rising edge sees.
  task automatic monitor();
    logic [DATA_W:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (en_out_mem && out_mem_read) begin
          checks++;
          if (out_mem_addr !== ADDR_W'(issued_cnt)) begin
            errors++;
            $display("FAIL read_addr got %0d expected %0d", out_mem_addr, issued_cnt);
          end
          issued_cnt++;
        end
        if (stalled) begin
          checks++;
          if (pix_data !== stall_data) begin
            errors++;
            $display("FAIL stall_stable got %0h expected %0h", pix_data, stall_data);
          end
        end
        if (pix_valid && pix_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat got data %0h with empty expected queue", pix_data);
          end else begin
            e = exp_q.pop_front();
            if ({pix_last, pix_data} !== e) begin
              errors++;
              $display("FAIL beat got last=%0b data=%0h expected last=%0b data=%0h",
                       pix_last, pix_data, e[DATA_W], e[DATA_W-1:0]);
            end
          end
          if (hs_cnt == 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          hs_cnt++;
        end
        stalled    = pix_valid && !pix_ready;
        stall_data = pix_data;
        if (issued_cnt - hs_cnt > max_out) max_out = issued_cnt - hs_cnt;
        if (stream_done) begin
          done_cnt++;
          checks++;
          if (cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL done_timing got cycle %0d expected %0d", cyc, last_hs_cyc + 1);
          end
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({en_out_mem, out_mem_read, out_mem_addr, pix_valid, pix_data, pix_last, busy,
         stream_done, stream_cksum, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0b addr=%0h busy=%0b state=%0d expected all 0",
               pix_valid, out_mem_addr, busy, dbg_state);
    end
    checks++;
    if ({en1, rd1, addr1, valid1, data1, last1, busy1, done1, cksum1, dbg1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs1 got valid=%0b busy=%0b state=%0d expected all 0",
               valid1, busy1, dbg1);
    end
  endtask

  task automatic test_full_rate();
    reset_counters();
    pix_ready = 1'b1;
    pulse_start(1'b1);
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_c1 got valid=%0b busy=%0b expected valid=0 busy=1", pix_valid, busy);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_c2 got valid=%0b expected 0", pix_valid);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'h00) begin
      errors++;
      $display("FAIL latency_first got valid=%0b data=%0h expected valid=1 data=0", pix_valid, pix_data);
    end
    run_until_done(0, 1'b0);
    checks++;
    if (hs_cnt != NUM_PIX || last_hs_cyc - first_hs_cyc != NUM_PIX - 1) begin
      errors++;
      $display("FAIL full_rate got beats=%0d span=%0d expected beats=%0d span=%0d",
               hs_cnt, last_hs_cyc - first_hs_cyc, NUM_PIX, NUM_PIX - 1);
    end
    checks++;
    if (issued_cnt != NUM_PIX || max_out > 2) begin
      errors++;
      $display("FAIL full_reads got reads=%0d max_out=%0d expected reads=%0d max_out<=2",
               issued_cnt, max_out, NUM_PIX);
    end
    checks++;
    if (stream_cksum !== exp_ck) begin
      errors++;
      $display("FAIL cksum got %0h expected %0h", stream_cksum, exp_ck);
    end
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_after got busy=%0b state=%0d expected busy=0 state=0", busy, dbg_state);
    end
  endtask

  task automatic test_stall_toggle();
    reset_counters();
    pulse_start(1'b1);
    run_until_done(1, 1'b0);
    checks++;
    if (hs_cnt != NUM_PIX || done_cnt != 1 || max_out > 2) begin
      errors++;
      $display("FAIL toggle got beats=%0d done=%0d max_out=%0d expected beats=%0d done=1 max_out<=2",
               hs_cnt, done_cnt, max_out, NUM_PIX);
    end
  endtask

  task automatic test_double_start();
    reset_counters();
    pulse_start(1'b1);
    run_until_done(0, 1'b1);
    repeat (4) tick();
    checks++;
    if (hs_cnt != NUM_PIX || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL double_start got beats=%0d done=%0d busy=%0b expected beats=%0d done=1 busy=0",
               hs_cnt, done_cnt, busy, NUM_PIX);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    reset_counters();
    pulse_start(1'b1);
    while (hs_cnt < 20 && n < 200) begin
      pix_ready = 1'b1;
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({en_out_mem, out_mem_read, out_mem_addr, pix_valid, pix_data, pix_last, busy,
         stream_done, stream_cksum, dbg_state} !== '0 || hs_cnt != 20) begin
      errors++;
      $display("FAIL reset_mid got valid=%0b addr=%0h busy=%0b beats=%0d expected all 0 after 20 beats",
               pix_valid, out_mem_addr, busy, hs_cnt);
    end
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d expected 0", done_cnt);
    end
    reset_counters();
    tick();
    pulse_start(1'b1);
    run_until_done(0, 1'b0);
    checks++;
    if (hs_cnt != NUM_PIX || issued_cnt != NUM_PIX || done_cnt != 1) begin
      errors++;
      $display("FAIL restream got beats=%0d reads=%0d done=%0d expected %0d %0d 1",
               hs_cnt, issued_cnt, done_cnt, NUM_PIX, NUM_PIX);
    end
  endtask

  task automatic test_ready_low();
    reset_counters();
    pix_ready = 1'b0;
    pulse_start(1'b1);
    repeat (10) tick();
    checks++;
    if (issued_cnt != 2 || out_mem_addr !== ADDR_W'(2) || max_out > 2) begin
      errors++;
      $display("FAIL ready_low_reads got reads=%0d addr=%0d max_out=%0d expected reads=2 addr=2",
               issued_cnt, out_mem_addr, max_out);
    end
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'h00) begin
      errors++;
      $display("FAIL ready_low_hold got valid=%0b data=%0h expected valid=1 data=0", pix_valid, pix_data);
    end
    run_until_done(0, 1'b0);
    checks++;
    if (hs_cnt != NUM_PIX || done_cnt != 1) begin
      errors++;
      $display("FAIL ready_low_done got beats=%0d done=%0d expected %0d 1", hs_cnt, done_cnt, NUM_PIX);
    end
  endtask

  task automatic test_single_pixel();
    logic [DATA_W:0] exp1_q[$];
    logic [DATA_W:0] e;
    int beats = 0, busy_cyc = 0, dones = 0, reads = 0, beat_at = -10, done_at = -20;
    logic [15:0] exp_ck1;
`ifdef SIPU_STREAM_CKSUM_EN
    exp_ck1 = 16'h00A5;
`else
    exp_ck1 = 16'h0000;
`endif
    exp1_q.push_back({1'b1, 8'hA5});
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy1) busy_cyc++;
      if (en1 && rd1) reads++;
      if (done1) begin dones++; done_at = i; end
      if (valid1 && ready1) begin
        beats++;
        beat_at = i;
        checks++;
        if (exp1_q.size() == 0) begin
          errors++;
          $display("FAIL single_extra got data %0h with empty expected queue", data1);
        end else begin
          e = exp1_q.pop_front();
          if ({last1, data1} !== e) begin
            errors++;
            $display("FAIL single_beat got last=%0b data=%0h expected last=%0b data=%0h",
                     last1, data1, e[DATA_W], e[DATA_W-1:0]);
          end
        end
      end
      tick();
    end
    checks++;
    if (beats != 1 || reads != 1 || dones != 1 || done_at != beat_at + 1) begin
      errors++;
      $display("FAIL single_flow got beats=%0d reads=%0d dones=%0d done_at=%0d beat_at=%0d expected 1 1 1 beat+1",
               beats, reads, dones, done_at, beat_at);
    end
    checks++;
    if (busy_cyc != 3) begin
      errors++;
      $display("FAIL single_busy got %0d cycles expected 3", busy_cyc);
    end
    checks++;
    if (cksum1 !== exp_ck1) begin
      errors++;
      $display("FAIL single_cksum got %0h expected %0h", cksum1, exp_ck1);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_counters();
    fork
      monitor();
    join_none
    test_reset();
    test_full_rate();
    test_stall_toggle();
    test_double_start();
    test_reset_mid();
    test_ready_low();
    test_single_pixel();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
